// File: rtl/i2s_frame_scheduler.sv
// rtl/i2s_frame_scheduler.sv - pairs L/R I2S samples, runs them through one shared DSP core, commits frames
module i2s_frame_scheduler #(
  parameter int DATA_WIDTH     = 24,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] rx_l_sample,
  input  logic                  rx_l_tgl,
  input  logic [DATA_WIDTH-1:0] rx_r_sample,
  input  logic                  rx_r_tgl,
  input  logic                  bypass,
  output logic                  core_in_valid,
  input  logic                  core_in_ready,
  output logic [DATA_WIDTH-1:0] core_in_data,
  output logic                  core_in_chan,
  input  logic                  core_out_valid,
  output logic                  core_out_ready,
  input  logic [DATA_WIDTH-1:0] core_out_data,
  input  logic                  core_out_chan,
  output logic                  core_abort,
  output logic [DATA_WIDTH-1:0] tx_sample_l,
  output logic [DATA_WIDTH-1:0] tx_sample_r,
  output logic                  frame_done,
  output logic [CNT_WIDTH-1:0]  overrun_cnt,
  output logic [CNT_WIDTH-1:0]  timeout_cnt,
  output logic                  proto_err
);

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE_L,
    S_WAIT_L,
    S_ISSUE_R,
    S_WAIT_R,
    S_COMMIT
  } state_t;

  // Toggle synchronisers and edge detection
  logic [SYNC_STAGES-1:0] sync_l_q, sync_r_q;
  logic                   prev_l_q, prev_r_q;
  logic                   edge_l, edge_r;

  // Pending sample buffers
  logic                   pend_l_q, pend_r_q;
  logic [DATA_WIDTH-1:0]  buf_l_q, buf_r_q;
  logic [CNT_WIDTH-1:0]   overrun_cnt_q;
  logic                   consume;
  logic                   ovr_l, ovr_r;
  logic [1:0]             ovr_inc;

  // Sequencer state and registered outputs
  state_t                 state_q;
  logic [TW-1:0]          timer_q;
  logic [TW-1:0]          timer_inc;
  logic                   timer_hit;
  logic [DATA_WIDTH-1:0]  work_r_q;
  logic [DATA_WIDTH-1:0]  res_l_q;
  logic                   core_in_valid_q;
  logic [DATA_WIDTH-1:0]  core_in_data_q;
  logic                   core_in_chan_q;
  logic                   core_out_ready_q;
  logic                   core_abort_q;
  logic [DATA_WIDTH-1:0]  tx_l_q, tx_r_q;
  logic                   frame_done_q;
  logic [CNT_WIDTH-1:0]   timeout_cnt_q;
  logic                   proto_err_q;
  logic                   in_fire, out_fire;
  logic [CNT_WIDTH-1:0]   timeout_cnt_inc;

  function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] a,
                                                   input logic [1:0] inc);
    logic [CNT_WIDTH:0] s;
    s = {1'b0, a} + {{(CNT_WIDTH-1){1'b0}}, inc};
    return s[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : s[CNT_WIDTH-1:0];
  endfunction

  assign edge_l  = sync_l_q[SYNC_STAGES-1] ^ prev_l_q;
  assign edge_r  = sync_r_q[SYNC_STAGES-1] ^ prev_r_q;
  assign consume = (state_q == S_IDLE) && pend_l_q && pend_r_q;
  // A new edge in the consume cycle refills the buffer for the next frame, so it is not an overrun.
  assign ovr_l   = edge_l && pend_l_q && !consume;
  assign ovr_r   = edge_r && pend_r_q && !consume;
  assign ovr_inc = {1'b0, ovr_l} + {1'b0, ovr_r};

  assign in_fire   = core_in_valid_q && core_in_ready;
  assign out_fire  = core_out_valid && core_out_ready_q;
  // Timer parks at the deadline so a late handshake cannot wrap it and extend the next wait.
  assign timer_hit = (timer_q == TIMER_MAX);
  assign timer_inc = timer_hit ? timer_q : timer_q + 1'b1;
  assign timeout_cnt_inc = (timeout_cnt_q == {CNT_WIDTH{1'b1}}) ? timeout_cnt_q : timeout_cnt_q + 1'b1;

  // Bring both bclk-domain toggles into clk and remember the last synchronised level.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_l_q <= '0;
      sync_r_q <= '0;
      prev_l_q <= 1'b0;
      prev_r_q <= 1'b0;
    end else begin
      sync_l_q <= {sync_l_q[SYNC_STAGES-2:0], rx_l_tgl};
      sync_r_q <= {sync_r_q[SYNC_STAGES-2:0], rx_r_tgl};
      prev_l_q <= sync_l_q[SYNC_STAGES-1];
      prev_r_q <= sync_r_q[SYNC_STAGES-1];
    end
  end

  // Capture new samples into the pending buffers and count overwrites of unconsumed samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_l_q      <= 1'b0;
      pend_r_q      <= 1'b0;
      buf_l_q       <= '0;
      buf_r_q       <= '0;
      overrun_cnt_q <= '0;
    end else begin
      pend_l_q <= edge_l || (pend_l_q && !consume);
      pend_r_q <= edge_r || (pend_r_q && !consume);
      if (edge_l) buf_l_q <= rx_l_sample;
      if (edge_r) buf_r_q <= rx_r_sample;
      overrun_cnt_q <= sat_add(overrun_cnt_q, ovr_inc);
    end
  end

  // Frame sequencer: issue L then R to the core, enforce deadlines, commit both channels at once.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= S_IDLE;
      timer_q          <= '0;
      work_r_q         <= '0;
      res_l_q          <= '0;
      core_in_valid_q  <= 1'b0;
      core_in_data_q   <= '0;
      core_in_chan_q   <= 1'b0;
      core_out_ready_q <= 1'b0;
      core_abort_q     <= 1'b0;
      tx_l_q           <= '0;
      tx_r_q           <= '0;
      frame_done_q     <= 1'b0;
      timeout_cnt_q    <= '0;
      proto_err_q      <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      core_abort_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (consume) begin
            work_r_q <= buf_r_q;
            if (bypass) begin
              tx_l_q       <= buf_l_q;
              tx_r_q       <= buf_r_q;
              frame_done_q <= 1'b1;
              state_q      <= S_COMMIT;
            end else begin
              timer_q         <= '0;
              core_in_valid_q <= 1'b1;
              core_in_data_q  <= buf_l_q;
              core_in_chan_q  <= 1'b0;
              state_q         <= S_ISSUE_L;
            end
          end
        end

        S_ISSUE_L: begin
          if (in_fire) begin
            core_in_valid_q  <= 1'b0;
            core_out_ready_q <= 1'b1;
            timer_q          <= timer_inc;
            state_q          <= S_WAIT_L;
          end else if (timer_hit) begin
            // Left missed its deadline: hold the last committed left sample and move on to right.
            res_l_q         <= tx_l_q;
            core_abort_q    <= 1'b1;
            timeout_cnt_q   <= timeout_cnt_inc;
            timer_q         <= '0;
            core_in_valid_q <= 1'b1;
            core_in_data_q  <= work_r_q;
            core_in_chan_q  <= 1'b1;
            state_q         <= S_ISSUE_R;
          end else begin
            timer_q <= timer_inc;
          end
        end

        S_WAIT_L: begin
          if (out_fire && !core_out_chan) begin
            res_l_q          <= core_out_data;
            core_out_ready_q <= 1'b0;
            timer_q          <= '0;
            core_in_valid_q  <= 1'b1;
            core_in_data_q   <= work_r_q;
            core_in_chan_q   <= 1'b1;
            state_q          <= S_ISSUE_R;
          end else begin
            // A result tagged for the other channel is dropped and flagged.
            if (out_fire) proto_err_q <= 1'b1;
            if (timer_hit) begin
              res_l_q          <= tx_l_q;
              core_abort_q     <= 1'b1;
              timeout_cnt_q    <= timeout_cnt_inc;
              core_out_ready_q <= 1'b0;
              timer_q          <= '0;
              core_in_valid_q  <= 1'b1;
              core_in_data_q   <= work_r_q;
              core_in_chan_q   <= 1'b1;
              state_q          <= S_ISSUE_R;
            end else begin
              timer_q <= timer_inc;
            end
          end
        end

        S_ISSUE_R: begin
          if (in_fire) begin
            core_in_valid_q  <= 1'b0;
            core_out_ready_q <= 1'b1;
            timer_q          <= timer_inc;
            state_q          <= S_WAIT_R;
          end else if (timer_hit) begin
            core_abort_q    <= 1'b1;
            timeout_cnt_q   <= timeout_cnt_inc;
            core_in_valid_q <= 1'b0;
            tx_l_q          <= res_l_q;
            frame_done_q    <= 1'b1;
            state_q         <= S_COMMIT;
          end else begin
            timer_q <= timer_inc;
          end
        end

        S_WAIT_R: begin
          if (out_fire && core_out_chan) begin
            core_out_ready_q <= 1'b0;
            tx_l_q           <= res_l_q;
            tx_r_q           <= core_out_data;
            frame_done_q     <= 1'b1;
            state_q          <= S_COMMIT;
          end else begin
            if (out_fire) proto_err_q <= 1'b1;
            if (timer_hit) begin
              // Right missed its deadline: tx_r keeps its last committed value.
              core_abort_q     <= 1'b1;
              timeout_cnt_q    <= timeout_cnt_inc;
              core_out_ready_q <= 1'b0;
              tx_l_q           <= res_l_q;
              frame_done_q     <= 1'b1;
              state_q          <= S_COMMIT;
            end else begin
              timer_q <= timer_inc;
            end
          end
        end

        S_COMMIT: begin
          state_q <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign core_in_valid  = core_in_valid_q;
  assign core_in_data   = core_in_data_q;
  assign core_in_chan   = core_in_chan_q;
  assign core_out_ready = core_out_ready_q;
  assign core_abort     = core_abort_q;
  assign tx_sample_l    = tx_l_q;
  assign tx_sample_r    = tx_r_q;
  assign frame_done     = frame_done_q;
  assign overrun_cnt    = overrun_cnt_q;
  assign timeout_cnt    = timeout_cnt_q;
  assign proto_err      = proto_err_q;

endmodule

// File: tb/tb_i2s_frame_scheduler.sv
// tb/tb_i2s_frame_scheduler.sv - directed table and sequence bench for i2s_frame_scheduler
module tb_i2s_frame_scheduler;

  localparam int DW = 24;
  localparam int CW = 16;

  logic          clk;
  logic          rst;
  logic [DW-1:0] rx_l_sample, rx_r_sample;
  logic          rx_l_tgl, rx_r_tgl;
  logic          bypass;
  logic          core_in_valid, core_in_ready, core_in_chan;
  logic [DW-1:0] core_in_data;
  logic          core_out_valid, core_out_ready, core_out_chan;
  logic [DW-1:0] core_out_data;
  logic          core_abort;
  logic [DW-1:0] tx_sample_l, tx_sample_r;
  logic          frame_done;
  logic [CW-1:0] overrun_cnt, timeout_cnt;
  logic          proto_err;

  i2s_frame_scheduler #(
    .DATA_WIDTH(DW), .SYNC_STAGES(2), .TIMEOUT_CYCLES(1024), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst),
    .rx_l_sample(rx_l_sample), .rx_l_tgl(rx_l_tgl),
    .rx_r_sample(rx_r_sample), .rx_r_tgl(rx_r_tgl),
    .bypass(bypass),
    .core_in_valid(core_in_valid), .core_in_ready(core_in_ready),
    .core_in_data(core_in_data), .core_in_chan(core_in_chan),
    .core_out_valid(core_out_valid), .core_out_ready(core_out_ready),
    .core_out_data(core_out_data), .core_out_chan(core_out_chan),
    .core_abort(core_abort),
    .tx_sample_l(tx_sample_l), .tx_sample_r(tx_sample_r),
    .frame_done(frame_done),
    .overrun_cnt(overrun_cnt), .timeout_cnt(timeout_cnt),
    .proto_err(proto_err)
  );

  initial clk = 1'b0;
  always #4 clk = ~clk;

  // Core model modes: 0 loopback +1, 1 drop left results, 2 wrong tag first on left, 3 drop right results
  int            core_mode;
  logic          fix_q;
  logic [DW-1:0] fix_data_q;

  always @(posedge clk) begin
    if (rst) begin
      core_out_valid <= 1'b0;
      core_out_data  <= '0;
      core_out_chan  <= 1'b0;
      fix_q          <= 1'b0;
      fix_data_q     <= '0;
    end else if (core_in_valid && core_in_ready) begin
      if ((core_mode == 1 && !core_in_chan) || (core_mode == 3 && core_in_chan)) begin
        core_out_valid <= 1'b0;
      end else if (core_mode == 2 && !core_in_chan) begin
        core_out_valid <= 1'b1;
        core_out_data  <= 24'h0BAD00;
        core_out_chan  <= 1'b1;
        fix_q          <= 1'b1;
        fix_data_q     <= DW'(core_in_data + 24'd1);
      end else begin
        core_out_valid <= 1'b1;
        core_out_data  <= DW'(core_in_data + 24'd1);
        core_out_chan  <= core_in_chan;
      end
    end else if (core_abort) begin
      core_out_valid <= 1'b0;
    end else if (core_out_valid && core_out_ready) begin
      if (fix_q) begin
        core_out_data <= fix_data_q;
        core_out_chan <= 1'b0;
        fix_q         <= 1'b0;
      end else begin
        core_out_valid <= 1'b0;
      end
    end
  end

  int checks;
  int errors;
  int vcnt, acnt, fcnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance to the next falling edge and tally observed pulses there.
  task automatic tick();
    @(negedge clk);
    if (core_in_valid) vcnt++;
    if (core_abort) acnt++;
    if (frame_done) fcnt++;
  endtask

  task automatic run_frame(input logic [DW-1:0] l, input logic [DW-1:0] r, input logic byp,
                           output int lat, output logic ok);
    rx_l_sample = l;
    rx_r_sample = r;
    bypass      = byp;
    rx_l_tgl    = ~rx_l_tgl;
    rx_r_tgl    = ~rx_r_tgl;
    lat = 0;
    ok  = 1'b0;
    for (int n = 1; n <= 3000; n++) begin
      tick();
      if (frame_done) begin
        lat = n;
        ok  = 1'b1;
        break;
      end
    end
    for (int n = 0; n < 4; n++) tick();
  endtask

  typedef struct {
    logic [DW-1:0] l;
    logic [DW-1:0] r;
    logic          byp;
    logic [DW-1:0] exp_l;
    logic [DW-1:0] exp_r;
    int            exp_lat;
    int            exp_valid;
  } vec_t;

  vec_t vecs[4];
  int   lat;
  logic ok;
  int   v0, a0, f0;
  logic found;

  initial begin
    checks = 0; errors = 0; vcnt = 0; acnt = 0; fcnt = 0;
    core_mode = 0;
    rst = 1'b1;
    rx_l_sample = '0; rx_r_sample = '0;
    rx_l_tgl = 1'b0; rx_r_tgl = 1'b0;
    bypass = 1'b0;
    core_in_ready = 1'b1;

    vecs[0] = '{24'h123456, 24'hFEDCBA, 1'b1, 24'h123456, 24'hFEDCBA, 4, 0};
    vecs[1] = '{24'h000010, 24'h7FFFFF, 1'b0, 24'h000011, 24'h800000, 8, 2};
    vecs[2] = '{24'hFFFFFF, 24'h000000, 1'b0, 24'h000000, 24'h000001, 8, 2};
    vecs[3] = '{24'h800000, 24'h7FFFFF, 1'b1, 24'h800000, 24'h7FFFFF, 4, 0};

    for (int n = 0; n < 3; n++) tick();
    check("rst_tx_l", 32'(tx_sample_l), 0);
    check("rst_tx_r", 32'(tx_sample_r), 0);
    check("rst_frame_done", 32'(frame_done), 0);
    check("rst_core_in_valid", 32'(core_in_valid), 0);
    check("rst_core_out_ready", 32'(core_out_ready), 0);
    check("rst_core_abort", 32'(core_abort), 0);
    check("rst_overrun_cnt", 32'(overrun_cnt), 0);
    check("rst_timeout_cnt", 32'(timeout_cnt), 0);
    check("rst_proto_err", 32'(proto_err), 0);
    rst = 1'b0;
    for (int n = 0; n < 3; n++) tick();

    // Table-driven frames: bypass and loopback with wrap boundaries
    for (int i = 0; i < 4; i++) begin
      v0 = vcnt; f0 = fcnt;
      run_frame(vecs[i].l, vecs[i].r, vecs[i].byp, lat, ok);
      check($sformatf("vec%0d_done", i), 32'(ok), 1);
      check($sformatf("vec%0d_tx_l", i), 32'(tx_sample_l), 32'(vecs[i].exp_l));
      check($sformatf("vec%0d_tx_r", i), 32'(tx_sample_r), 32'(vecs[i].exp_r));
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      check($sformatf("vec%0d_valid_cycles", i), 32'(vcnt - v0), 32'(vecs[i].exp_valid));
      check($sformatf("vec%0d_done_pulses", i), 32'(fcnt - f0), 1);
    end

    // Overrun: two left samples before the right one; the newest left is processed
    bypass = 1'b0;
    f0 = fcnt;
    rx_l_sample = 24'h0000AA; rx_l_tgl = ~rx_l_tgl;
    for (int n = 0; n < 6; n++) tick();
    rx_l_sample = 24'h0000BB; rx_l_tgl = ~rx_l_tgl;
    for (int n = 0; n < 6; n++) tick();
    check("ovr_no_frame_yet", 32'(fcnt - f0), 0);
    check("ovr_cnt", 32'(overrun_cnt), 1);
    rx_r_sample = 24'h000CCC; rx_r_tgl = ~rx_r_tgl;
    ok = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      tick();
      if (frame_done) begin ok = 1'b1; break; end
    end
    for (int n = 0; n < 4; n++) tick();
    check("ovr_done", 32'(ok), 1);
    check("ovr_tx_l", 32'(tx_sample_l), 32'h0000BC);
    check("ovr_tx_r", 32'(tx_sample_r), 32'h000CCD);

    // Wrong channel tag while waiting for left
    check("proto_before", 32'(proto_err), 0);
    core_mode = 2;
    run_frame(24'h000100, 24'h000200, 1'b0, lat, ok);
    check("proto_done", 32'(ok), 1);
    check("proto_err", 32'(proto_err), 1);
    check("proto_tx_l", 32'(tx_sample_l), 32'h000101);
    check("proto_tx_r", 32'(tx_sample_r), 32'h000201);
    check("proto_latency", 32'(lat), 9);

    // Left never returns: deadline abort, hold previous left, right still processed
    core_mode = 1;
    a0 = acnt;
    run_frame(24'h000555, 24'h000666, 1'b0, lat, ok);
    check("tmo_done", 32'(ok), 1);
    check("tmo_cnt", 32'(timeout_cnt), 1);
    check("tmo_abort_pulses", 32'(acnt - a0), 1);
    check("tmo_tx_l_held", 32'(tx_sample_l), 32'h000101);
    check("tmo_tx_r", 32'(tx_sample_r), 32'h000667);
    check("tmo_latency", 32'(lat), 1030);

    // Reset while waiting for the right result
    core_mode = 3;
    rx_l_sample = 24'h000700; rx_r_sample = 24'h000800;
    rx_l_tgl = ~rx_l_tgl; rx_r_tgl = ~rx_r_tgl;
    found = 1'b0;
    for (int n = 0; n < 50; n++) begin
      tick();
      if (core_out_ready && core_in_chan) begin found = 1'b1; break; end
    end
    check("rstmid_reached_wait_r", 32'(found), 1);
    a0 = acnt;
    rst = 1'b1; rx_l_tgl = 1'b0; rx_r_tgl = 1'b0;
    tick();
    check("rstmid_tx_l", 32'(tx_sample_l), 0);
    check("rstmid_tx_r", 32'(tx_sample_r), 0);
    check("rstmid_overrun", 32'(overrun_cnt), 0);
    check("rstmid_timeout", 32'(timeout_cnt), 0);
    check("rstmid_proto", 32'(proto_err), 0);
    check("rstmid_out_ready", 32'(core_out_ready), 0);
    check("rstmid_in_valid", 32'(core_in_valid), 0);
    rst = 1'b0;
    core_mode = 0;
    for (int n = 0; n < 3; n++) tick();
    check("rstmid_no_abort", 32'(acnt - a0), 0);
    run_frame(24'h000123, 24'h000456, 1'b0, lat, ok);
    check("after_rst_done", 32'(ok), 1);
    check("after_rst_tx_l", 32'(tx_sample_l), 32'h000124);
    check("after_rst_tx_r", 32'(tx_sample_r), 32'h000457);
    check("after_rst_latency", 32'(lat), 8);
    check("after_rst_timeout", 32'(timeout_cnt), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
